uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received character (8-bit data plus its parity-error flag) on the receiver's one-cycle done pulse and queues it for the bus/host side.
- Generates the rts_n flow-control level that the receiver and link partner use for hardware handshaking, with hysteresis.
- Provides level, full/empty, and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of entries; power of 2, range 4..256.
- RTS_HI, 12, level at or above which rts_n deasserts (goes 1); must satisfy RTS_LO < RTS_HI <= DEPTH.
- RTS_LO, 4, level at or below which rts_n reasserts (goes 0).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_done  in  1  one-cycle pulse from the receiver: character valid.
- rx_data  in  8  received character; for 5–7 bit frames, upper bits are 0. Qualified by rx_done.
- parity_error  in  1  parity flag for the character; qualified by rx_done.
- rd_en  in  1  host read request.
- rd_data  out  8  popped character.
- rd_perr  out  1  parity flag of the popped character.
- rd_valid  out  1  one-cycle pulse: rd_data/rd_perr valid.
- flush  in  1  discard all entries.
- ovf_clr  in  1  clear the sticky overflow flag.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: a character was dropped.
- rts_n  out  1  0 = ready to receive, 1 = stop sending.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers and level = 0; empty=1, full=0.
  - overflow=0, rts_n=0, rd_valid=0, rd_data=0, rd_perr=0.
  - Reset mid-operation discards all contents; it takes priority over every other input.
- Storage: 9-bit entries {parity_error, rx_data}, circular buffer.
  - Write/read pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
  - level is a separate counter.
- Read accept: rd_acc = rd_en & ~empty.
  - On accept: the entry at the read pointer is registered onto rd_data/rd_perr; rd_valid=1 on the next cycle (latency 1). Read pointer increments.
  - rd_en while empty is ignored: rd_valid=0, rd_data holds its last value, no error flag.
- Write accept: wr_acc = rx_done & (~full | rd_acc).
  - The entry is written at the write pointer, which then increments.
  - Full with simultaneous read: both occur; level unchanged.
  - Empty with simultaneous rx_done and rd_en: write only; no fall-through; rd_valid stays 0.
- Overflow:
  - rx_done & full & ~rd_acc drops the character; overflow <= 1 and stays 1.
  - ovf_clr clears it; if a set event and ovf_clr occur in the same cycle, set wins.
- level update:
  - +1 on write only; -1 on read only; unchanged on both or neither.
  - empty and full are combinational decodes of the level register.
- flush (priority below rst, above reads and writes):
  - Pointers and level go to 0.
  - Any same-cycle rx_done is dropped without setting overflow; any same-cycle rd_en is ignored.
  - overflow is not affected.
- rts_n: registered from the level register, so it changes one cycle after level crosses a threshold.
  - If level >= RTS_HI, rts_n <= 1.
  - Else if level <= RTS_LO, rts_n <= 0.
  - Otherwise rts_n holds (hysteresis).
  - After flush, rts_n returns to 0 one cycle after level becomes 0.
- Character boundaries: rx_done pulses are at least one frame apart in normal operation, but the block must also accept back-to-back pulses on consecutive cycles.

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 with parity_error 0,1,0, then rd_en for 3 cycles -> rd_valid pulses carry 0x41/0, 0x42/1, 0x43/0 in order, each one cycle after rd_en. level goes 3 -> 0; empty=1 at the end.
- Fill 16 entries, then one more rx_done (0x99) -> full=1, overflow=1, 0x99 absent on readback. Assert ovf_clr -> overflow=0. Assert ovf_clr together with another drop -> overflow stays 1.
- Full FIFO with rx_done and rd_en in the same cycle -> oldest entry is read, new entry is stored at the tail, level stays 16, overflow stays 0.
- Write 12 entries -> rts_n=1 one cycle after level reaches 12. Read down to 5 -> rts_n still 1. Read to 4 -> rts_n=0 one cycle later.
- Write 20 / read 20 interleaved, crossing pointer wrap twice -> data order is preserved and no spurious full/empty.
- Level 7, assert flush with a simultaneous rx_done -> level=0, empty=1, overflow unchanged, rts_n=0. A subsequent read returns the first post-flush character.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: queues {parity_error, rx_data} characters,
// tracks level/full/empty, a sticky overflow flag and an rts_n handshake with hysteresis.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int RTS_HI = 12,
    parameter int RTS_LO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     parity_error,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_perr,
    output logic                     rd_valid,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     rts_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_HI   = LW'(RTS_HI);
    localparam logic [LW-1:0] LVL_LO   = LW'(RTS_LO);

    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [7:0]    rd_data_r;
    logic          rd_perr_r;
    logic          rd_valid_r;
    logic          overflow_r;
    logic          rts_n_r;

    logic          empty_s;
    logic          full_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          drop_s;

    // Accept decodes; flush suppresses both sides and never counts as a drop.
    always_comb begin
        empty_s  = (level_r == {LW{1'b0}});
        full_s   = (level_r == LVL_FULL);
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        drop_s   = 1'b0;
        if (flush) begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
            drop_s   = 1'b0;
        end else begin
            rd_acc_s = rd_en & ~empty_s;
            wr_acc_s = rx_done & (~full_s | rd_acc_s);
            drop_s   = rx_done & full_s & ~rd_acc_s;
        end
    end

    // Character storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= {parity_error, rx_data};
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // Read port: popped entry appears one cycle after the accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= 8'h00;
            rd_perr_r  <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                {rd_perr_r, rd_data_r} <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Flow control from the registered level, holding between the thresholds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rts_n_r <= 1'b0;
        end else if (level_r >= LVL_HI) begin
            rts_n_r <= 1'b1;
        end else if (level_r <= LVL_LO) begin
            rts_n_r <= 1'b0;
        end else begin
            rts_n_r <= rts_n_r;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_perr  = rd_perr_r;
    assign rd_valid = rd_valid_r;
    assign empty    = empty_s;
    assign full     = full_s;
    assign level    = level_r;
    assign overflow = overflow_r;
    assign rts_n    = rts_n_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, RTS_HI=12, RTS_LO=4).
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       parity_error;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_valid;
    logic       flush;
    logic       ovf_clr;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       rts_n;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q [$];

    uart_rx_fifo #(.DEPTH(16), .RTS_HI(12), .RTS_LO(4)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .parity_error(parity_error), .rd_en(rd_en), .rd_data(rd_data),
        .rd_perr(rd_perr), .rd_valid(rd_valid), .flush(flush), .ovf_clr(ovf_clr),
        .empty(empty), .full(full), .level(level), .overflow(overflow), .rts_n(rts_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, sample 1ns later, then idle inputs.
    task automatic step(input logic wr, input logic [7:0] d, input logic pe,
                        input logic rd, input logic fl, input logic clr);
        rx_done = wr; rx_data = d; parity_error = pe;
        rd_en = rd; flush = fl; ovf_clr = clr;
        @(posedge clk);
        #1;
        rx_done = 1'b0; rx_data = 8'h00; parity_error = 1'b0;
        rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        step(1'b1, d, pe, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic pe);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk({tag, "_valid"}, rd_valid, 1'b1);
        chk({tag, "_data"}, rd_data, d);
        chk({tag, "_perr"}, rd_perr, pe);
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; parity_error = 1'b0;
        rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_rts", rts_n, 1'b0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 8'h00);
        chk("rst_perr", rd_perr, 1'b0);

        // Basic ordering, back-to-back writes and reads
        push(8'h41, 1'b0);
        push(8'h42, 1'b1);
        push(8'h43, 1'b0);
        chk("t1_level3", level, 5'd3);
        pop_chk("t1_r0", 8'h41, 1'b0);
        chk("t1_level2", level, 5'd2);
        pop_chk("t1_r1", 8'h42, 1'b1);
        pop_chk("t1_r2", 8'h43, 1'b0);
        chk("t1_level0", level, 5'd0);
        chk("t1_empty", empty, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_rd_empty_valid", rd_valid, 1'b0);
        chk("t1_rd_empty_hold", rd_data, 8'h43);
        chk("t1_rd_empty_level", level, 5'd0);

        // Empty with simultaneous write and read: write only, no fall-through
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1b_valid", rd_valid, 1'b0);
        chk("t1b_level", level, 5'd1);
        pop_chk("t1b_r", 8'h55, 1'b1);

        // Fill to 16, then overflow behaviour
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'(i));
        chk("t2_full", full, 1'b1);
        chk("t2_level16", level, 5'd16);
        chk("t2_ovf0", overflow, 1'b0);
        push(8'h99, 1'b0);
        chk("t2_ovf_set", overflow, 1'b1);
        chk("t2_level_hold", level, 5'd16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_ovf_clr", overflow, 1'b0);
        step(1'b1, 8'h98, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_ovf_set_wins", overflow, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_ovf_clr2", overflow, 1'b0);

        // Full with simultaneous write and read
        step(1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_valid", rd_valid, 1'b1);
        chk("t3_data", rd_data, 8'h10);
        chk("t3_perr", rd_perr, 1'b0);
        chk("t3_level", level, 5'd16);
        chk("t3_ovf", overflow, 1'b0);
        chk("t3_rts_full", rts_n, 1'b1);
        for (int i = 1; i < 16; i++) pop_chk("t3_drain", 8'h10 + 8'(i), 1'(i));
        pop_chk("t3_tail", 8'hA0, 1'b1);
        chk("t3_empty", empty, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_rts_back", rts_n, 1'b0);

        // rts_n hysteresis
        for (int i = 0; i < 11; i++) push(8'h30 + 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_rts_l11", rts_n, 1'b0);
        push(8'h3B, 1'b0);
        chk("t4_level12", level, 5'd12);
        chk("t4_rts_lag", rts_n, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_rts_hi", rts_n, 1'b1);
        for (int i = 0; i < 7; i++) pop_chk("t4_pop", 8'h30 + 8'(i), 1'b0);
        chk("t4_level5", level, 5'd5);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_rts_l5", rts_n, 1'b1);
        pop_chk("t4_pop7", 8'h37, 1'b0);
        chk("t4_level4", level, 5'd4);
        chk("t4_rts_lag4", rts_n, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_rts_lo", rts_n, 1'b0);
        for (int i = 8; i < 12; i++) pop_chk("t4_pop_rest", 8'h30 + 8'(i), 1'b0);
        chk("t4_empty", empty, 1'b1);

        // Interleaved traffic across pointer wraps with a 3-deep queue
        for (int i = 0; i < 3; i++) begin
            push(8'h50 + 8'(i), 1'(i >> 1));
            exp_q.push_back({1'(i >> 1), 8'h50 + 8'(i)});
        end
        for (int i = 3; i < 43; i++) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            exp_q.push_back({1'(i >> 1), 8'h50 + 8'(i)});
            step(1'b1, 8'h50 + 8'(i), 1'(i >> 1), 1'b1, 1'b0, 1'b0);
            chk("t5_valid", rd_valid, 1'b1);
            chk("t5_entry", {rd_perr, rd_data}, e);
            chk("t5_level", level, 5'd3);
            chk("t5_flags", {full, empty}, 2'b00);
        end
        while (exp_q.size() > 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            pop_chk("t5_drain", e[7:0], e[8]);
        end
        chk("t5_empty", empty, 1'b1);

        // Flush with a simultaneous write
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i), 1'b0);
        chk("t6_level7", level, 5'd7);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_level0", level, 5'd0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_valid", rd_valid, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_rts", rts_n, 1'b0);
        push(8'h7A, 1'b1);
        chk("t6_level1", level, 5'd1);
        pop_chk("t6_post", 8'h7A, 1'b1);

        // Flush from above RTS_HI keeps a set overflow and drops rts_n after one cycle
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b0);
        push(8'hEE, 1'b0);
        chk("t7_ovf", overflow, 1'b1);
        chk("t7_rts", rts_n, 1'b1);
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t7_level0", level, 5'd0);
        chk("t7_ovf_kept", overflow, 1'b1);
        chk("t7_rts_lag", rts_n, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t7_rts_lo", rts_n, 1'b0);

        // Reset mid-operation
        push(8'hC1, 1'b1);
        rst = 1'b1;
        step(1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t8_level", level, 5'd0);
        chk("t8_ovf", overflow, 1'b0);
        chk("t8_valid", rd_valid, 1'b0);
        chk("t8_data", rd_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
